// File: rtl/issue_execute_fifo_pkg.sv
// issue_execute_fifo shared types and sizing.
// Issue->execute entry bundle and per-unit FIFO depth.
package issue_execute_fifo_pkg;

  localparam int ISSUE_EXEC_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [5:0]  rob_id;
    logic [4:0]  rd;
    logic [3:0]  opcode;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } issue_execute_pack_t;

  localparam int PACK_W = $bits(issue_execute_pack_t);

endpackage

// File: rtl/issue_execute_fifo_ptr.sv
// fifo_ptr: wrap-bit pointer for issue_execute_fifo.
// Increments by one; synchronous clear dominates.
import issue_execute_fifo_pkg::*;

module fifo_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);

  // pointer register: clear beats increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (clr)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + W'(1);
  end

endmodule

// File: rtl/issue_execute_fifo.sv
// issue_execute_fifo: FWFT queue from issue to one execute unit.
// Optional stall counter under ISSUE_EXECUTE_FIFO_PERF_EN.
import issue_execute_fifo_pkg::*;

module issue_execute_fifo #(
  parameter int DEPTH = ISSUE_EXEC_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PACK_W-1:0]          data_in,
  input  logic                       push,
  output logic                       full,
  output logic [PACK_W-1:0]          data_out,
  output logic                       data_out_valid,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
`ifdef ISSUE_EXECUTE_FIFO_PERF_EN
  ,
  output logic [31:0]                push_stall_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PACK_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rptr;
  logic [PW-1:0]     wptr;
  logic              empty;
  logic              push_ok;
  logic              pop_ok;

  // status from registered pointers only
  always_comb begin
    empty = (rptr == wptr);
    full  = (rptr[AW-1:0] == wptr[AW-1:0])
         && (rptr[AW] != wptr[AW]);
    count = wptr - rptr;
    data_out       = mem[rptr[AW-1:0]];
    data_out_valid = !empty;
    push_ok = push && !full && !flush;
    pop_ok  = pop && !empty && !flush;
  end

  // storage write; contents survive flush
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wptr[AW-1:0]] <= data_in;
  end

  fifo_ptr #(.W(PW)) u_wptr (
    .clk (clk),
    .rst (rst),
    .inc (push_ok),
    .clr (flush),
    .ptr (wptr)
  );

  fifo_ptr #(.W(PW)) u_rptr (
    .clk (clk),
    .rst (rst),
    .inc (pop_ok),
    .clr (flush),
    .ptr (rptr)
  );

`ifdef ISSUE_EXECUTE_FIFO_PERF_EN
  // saturating count of pushes refused for lack of space
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      push_stall_count <= '0;
    else if (push && full && !flush
             && push_stall_count != 32'hFFFF_FFFF)
      push_stall_count <= push_stall_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_issue_execute_fifo.sv
// tb_issue_execute_fifo: queue-model scoreboard plus
// directed vectors with literal expectations.
import issue_execute_fifo_pkg::*;

module tb_issue_execute_fifo;

  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PACK_W-1:0] data_in = '0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic              flush = 1'b0;
  logic              full;
  logic [PACK_W-1:0] data_out;
  logic              data_out_valid;
  logic [2:0]        count;
`ifdef ISSUE_EXECUTE_FIFO_PERF_EN
  logic [31:0]       push_stall_count;
`endif

  issue_execute_pack_t dout;
  assign dout = data_out;

  int n_cmp = 0;
  int n_bad = 0;

  issue_execute_fifo #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .push           (push),
    .full           (full),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .pop            (pop),
    .flush          (flush),
    .count          (count)
`ifdef ISSUE_EXECUTE_FIFO_PERF_EN
    ,
    .push_stall_count (push_stall_count)
`endif
  );

  always #5 clk = ~clk;

  // reference model: an ordered queue of entries
  issue_execute_pack_t mq[$];
  longint m_stall;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_stall = 0;
    end else begin
      automatic bit was_full = (mq.size() == DEPTH);
      automatic bit was_empty = (mq.size() == 0);
      if (push && was_full && !flush
          && m_stall != 64'hFFFF_FFFF)
        m_stall = m_stall + 1;
      if (flush) begin
        mq.delete();
      end else begin
        if (pop && !was_empty)
          void'(mq.pop_front());
        if (push && !was_full)
          mq.push_back(issue_execute_pack_t'(data_in));
      end
    end
  end

  task automatic chk(string name, longint act,
                     longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_full", full, mq.size() == DEPTH);
      chk("m_valid", data_out_valid, mq.size() != 0);
      chk("m_count", count, mq.size());
      if (mq.size() != 0)
        chk("m_head", dout.rob_id, mq[0].rob_id);
`ifdef ISSUE_EXECUTE_FIFO_PERF_EN
      chk("m_stall", push_stall_count, m_stall);
`endif
    end
  end

  function automatic logic [PACK_W-1:0] mk(int rob);
    issue_execute_pack_t p;
    p = '0;
    p.rob_id = 6'(rob);
    p.rd = 5'(rob + 3);
    p.op_a = 32'hA000_0000 + 32'(rob);
    p.op_b = 32'h0B00_0000 - 32'(rob);
    return p;
  endfunction

  // one cycle of stimulus; returns #1 after the edge
  task automatic cyc(bit ps, int rob, bit pp, bit fl);
    push = ps;
    data_in = mk(rob);
    pop = pp;
    flush = fl;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    // reset then idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_full", full, 0);
    chk("rst_valid", data_out_valid, 0);
    chk("rst_count", count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // fill and drain
    for (int i = 1; i <= 4; i++) cyc(1, i, 0, 0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    cyc(1, 5, 0, 0);
    chk("drop_count", count, 4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", data_out_valid, 1);
      chk("drain_rob", dout.rob_id, i);
      cyc(0, 0, 1, 0);
    end
    chk("drain_empty", data_out_valid, 0);
    chk("drain_count", count, 0);

    // push while full with pop high is still dropped
    for (int i = 1; i <= 4; i++) cyc(1, 10 + i, 0, 0);
    cyc(1, 30, 1, 0);
    chk("fullpp_count", count, 3);
    chk("fullpp_head", dout.rob_id, 12);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    chk("fullpp_empty", data_out_valid, 0);

    // simultaneous push/pop across pointer wrap
    cyc(1, 20, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("wrap_head", dout.rob_id, i == 0 ? 20 : i - 1);
      cyc(1, i, 1, 0);
      chk("wrap_count", count, 1);
    end
    chk("wrap_last", dout.rob_id, 9);
    cyc(0, 0, 1, 0);

    // push and pop together while empty
    cyc(1, 7, 1, 0);
    chk("ep_valid", data_out_valid, 1);
    chk("ep_rob", dout.rob_id, 7);
    chk("ep_count", count, 1);
    cyc(0, 0, 1, 0);

    // flush dominates push and pop
    for (int i = 1; i <= 3; i++) cyc(1, 40 + i, 0, 0);
    cyc(1, 50, 1, 1);
    chk("fl_count", count, 0);
    chk("fl_valid", data_out_valid, 0);
    chk("fl_full", full, 0);
    cyc(1, 9, 0, 0);
    chk("fl_head", dout.rob_id, 9);
    chk("fl_hvalid", data_out_valid, 1);
    cyc(0, 0, 1, 0);

`ifdef ISSUE_EXECUTE_FIFO_PERF_EN
    for (int i = 1; i <= 4; i++) cyc(1, i, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 60, 0, 0);
    chk("perf_5", push_stall_count, 5);
    cyc(0, 0, 0, 1);
    chk("perf_flush", push_stall_count, 5);
    rst = 1'b1;
    #1;
    chk("perf_rst", push_stall_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
`endif

    // asynchronous reset mid-cycle
    cyc(1, 33, 0, 0);
    cyc(1, 34, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_valid", data_out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 35, 0, 0);
    chk("arst_head", dout.rob_id, 35);
    repeat (2) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/issue_execute_fifo.md
# issue_execute_fifo

Parameterised first-word-fall-through queue between the issue stage and one execute unit; instantiated per unit, e.g. as issue_mul_fifo in front of execute_mul. It accepts one issue_execute_pack_t per cycle from issue and presents the oldest entry combinationally to the execute unit. The execute unit pops the entry in the same cycle it consumes it. A commit-driven flush empties the queue.

## Interface
- DEPTH, 4, entry count; power of two, ≥ 2
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- data_in  input  $bits(issue_execute_pack_t)  entry from issue
- push  input  1  write request for data_in
- full  output  1  no free entry; registered-state derived
- data_out  output  $bits(issue_execute_pack_t)  oldest entry (head)
- data_out_valid  output  1  head entry exists
- pop  input  1  execute unit consumed head this cycle
- flush  input  1  discard all entries; driven from commit_feedback_pack.enable && commit_feedback_pack.flush
- count  output  $clog2(DEPTH)+1  current occupancy
- push_stall_count  output  32  only with ISSUE_EXECUTE_FIFO_PERF_EN (see Configuration)

## Operation
- Storage: DEPTH-entry array plus read and write pointers, each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
- empty = (rptr == wptr); full = index bits equal and wrap bits differ.
- count = wptr − rptr, modulo 2^($clog2(DEPTH)+1).
- data_out = mem[rptr index]; data_out_valid = !empty. Both are combinational from registered state only.
- Push accepted iff push && !full && !flush. On acceptance, mem[wptr] ← data_in and wptr+1.
- Push while full is dropped, even if pop is high in the same cycle. There is no push→full or pop→full combinational path.
- Pop accepted iff pop && !empty && !flush; rptr+1. Pop while empty is ignored.
- Push and pop in the same cycle, neither full nor empty: both are accepted and count is unchanged.
- Push and pop in the same cycle while empty: push is accepted, pop is ignored, count becomes 1.
- Flush: next cycle rptr = wptr = 0, count = 0. Flush dominates any same-cycle push and pop. Array contents are not cleared.
- Pointer wrap: the index wraps DEPTH−1 → 0 and toggles the wrap bit.
- data_out contents are undefined when data_out_valid = 0. Consumers gate on valid.

## Timing
- Reset (async assert, sync release): rptr = wptr = 0. Resulting outputs: full=0, data_out_valid=0, count=0, push_stall_count=0.
- Reset asserted mid-operation clears all state immediately, regardless of clk.
- Push-to-visible latency is 1 cycle. An entry pushed in cycle N has data_out_valid=1 in cycle N+1 if it is the head.
- Pop takes effect at the clock edge. The next head appears in the following cycle.
- full reflects the state after the previous edge. Issue must sample full before asserting push.
- Flush at edge N: data_out_valid=0 and full=0 from cycle N+1.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- ISSUE_EXECUTE_FIFO_PERF_EN defined:
  - push_stall_count port exists.
  - It increments on every cycle with push && full && !flush.
  - It saturates at 32'hFFFF_FFFF.
  - It is cleared only by rst; flush does not clear it.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Structure
- issue_execute_pack_t comes from the shared common package, unchanged.
- No new typedefs. DEPTH defaults to the per-unit FIFO size constant in config.svh.
- Sub-module fifo_ptr holds one wrap-bit pointer with increment and synchronous clear, async reset to 0. It is instantiated twice, for read and write.
- Storage array and full/empty/count logic live in the top module.

## Test plan
- Reset then idle: hold rst for 2 cycles → full=0, data_out_valid=0, count=0.
- Fill and drain, DEPTH=4:
  - Push rob_id 1,2,3,4 on consecutive cycles → full=1 after 4th edge, count=4.
  - 5th push (rob_id 5) is dropped.
  - Pop 4× → data_out.rob_id 1,2,3,4 in order, then data_out_valid=0.
- Wrap-around: push and pop simultaneously for 10 cycles with rob_id 0..9 after one pre-fill → FIFO order preserved across pointer wrap, count stays 1.
- Empty push+pop: empty queue, push rob_id 7 with pop=1 → next cycle data_out_valid=1, rob_id 7, count=1.
- Flush dominance: 3 entries held, then flush=1 with push=1 and pop=1 → next cycle count=0, data_out_valid=0. A following push of rob_id 9 appears as head.
- With ISSUE_EXECUTE_FIFO_PERF_EN: full queue, push held for 5 cycles → push_stall_count=5. Then flush → count stays 5; rst → 0.
